// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged reset release sequencer with software reset handshake
//
// Purpose:
//   Takes one synchronized active-low reset and releases NumOut reset domains
//   one after another. Bit 0 is released first. After the sequence starts, all
//   outputs stay asserted for MinAssertCycles. Consecutive releases are then
//   spaced DelayCycles apart. A 4-phase software request re-runs the whole
//   sequence, and the acknowledge completes together with done_o. In test
//   mode every output follows rst_ni directly, which gives scan control.
//
// Ports:
//   clk_i         in   1       clock
//   rst_ni        in   1       async active-low reset (release already synchronized)
//   test_mode_i   in   1       bypass: rst_no = rst_ni, done_o = 1, ack masked
//   sw_rst_req_i  in   1       software reset request (4-phase level)
//   sw_rst_ack_o  out  1       software reset acknowledge
//   rst_no        out  NumOut  sequenced active-low resets
//   done_o        out  1       all outputs released
//   rst_reason_o  out  1       0 = power-on reset, 1 = software reset
//                              (present only with RST_SEQUENCER_REASON_EN)
//
// Optional feature macro: RST_SEQUENCER_REASON_EN

module rst_sequencer #(
    parameter int NumOut          = 3,
    parameter int MinAssertCycles = 8,
    parameter int DelayCycles     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              test_mode_i,
    input  logic              sw_rst_req_i,
    output logic              sw_rst_ack_o,
    output logic [NumOut-1:0] rst_no,
    output logic              done_o
`ifdef RST_SEQUENCER_REASON_EN
    ,
    output logic              rst_reason_o
`endif
);

    localparam int MaxCycles = (MinAssertCycles > DelayCycles) ? MinAssertCycles : DelayCycles;
    localparam int CntWidth  = $clog2(MaxCycles + 1);
    localparam int StageW    = (NumOut > 1) ? $clog2(NumOut) : 1;

    localparam logic [CntWidth-1:0] AssertLast = CntWidth'(MinAssertCycles - 1);
    localparam logic [CntWidth-1:0] DelayLast  = CntWidth'(DelayCycles - 1);
    localparam logic [StageW-1:0]   StageLast  = StageW'(NumOut - 1);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    if (NumOut < 1 || MinAssertCycles < 1 || DelayCycles < 1) begin : g_param_check
        $fatal(1, "rst_sequencer: NumOut, MinAssertCycles and DelayCycles must be >= 1");
    end

    logic [1:0]          state_q;
    logic [CntWidth-1:0] cnt_q;
    logic [StageW-1:0]   stage_q;
    logic [NumOut-1:0]   rst_q;
    logic                done_q;
    logic                ack_q;
    logic                src_sw_q;
    logic                sw_trigger;

    // Requests raised while the sequence runs are held by the level itself.
    // They are picked up here once DONE is reached and the previous ack has cleared.
    assign sw_trigger = (state_q == ST_DONE) && sw_rst_req_i && !ack_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_ASSERT;
            cnt_q    <= '0;
            stage_q  <= '0;
            rst_q    <= '0;
            done_q   <= 1'b0;
            ack_q    <= 1'b0;
            src_sw_q <= 1'b0;
        end else begin
            if (ack_q && !sw_rst_req_i) begin
                ack_q <= 1'b0;
            end
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == AssertLast) begin
                        cnt_q <= '0;
                        rst_q <= rst_q | NumOut'(1);
                        if (NumOut == 1) begin
                            done_q  <= 1'b1;
                            ack_q   <= src_sw_q;
                            state_q <= ST_DONE;
                        end else begin
                            stage_q <= StageW'(1);
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == DelayLast) begin
                        cnt_q <= '0;
                        rst_q <= rst_q | (NumOut'(1) << stage_q);
                        if (stage_q == StageLast) begin
                            done_q  <= 1'b1;
                            ack_q   <= src_sw_q;
                            state_q <= ST_DONE;
                        end else begin
                            stage_q <= stage_q + StageW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                ST_DONE: begin
                    if (sw_trigger) begin
                        rst_q    <= '0;
                        done_q   <= 1'b0;
                        cnt_q    <= '0;
                        stage_q  <= '0;
                        src_sw_q <= 1'b1;
                        state_q  <= ST_ASSERT;
                    end
                end
                default: begin
                    state_q <= ST_ASSERT;
                end
            endcase
        end
    end

`ifdef RST_SEQUENCER_REASON_EN
    logic reason_q;

    // Sticky until the next hard reset, so firmware can read the cause after DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reason_q <= 1'b0;
        end else if (sw_trigger) begin
            reason_q <= 1'b1;
        end
    end

    assign rst_reason_o = reason_q;
`endif

    // The bypass is the only combinational path. Outside test mode every output is a flop.
    assign rst_no       = test_mode_i ? {NumOut{rst_ni}} : rst_q;
    assign done_o       = test_mode_i | done_q;
    assign sw_rst_ack_o = ack_q & ~test_mode_i;

endmodule
